// File: rtl/arbitro_acciones_if.sv
// arbitro_acciones_if: action command handshake between the button arbiter
// (master) and the pet state machine (slave).
interface arbitro_acciones_if;
    logic       accion_valida;
    logic [1:0] accion_codigo;
    logic       accion_listo;

    modport master (
        output accion_valida,
        output accion_codigo,
        input  accion_listo
    );

    modport slave (
        input  accion_valida,
        input  accion_codigo,
        output accion_listo
    );
endinterface

// File: rtl/arbitro_acciones.sv
// arbitro_acciones: turns the three pet buttons (Comida, Medicina, Test) into
// one action command at a time for the pet state machine. The command uses a
// valid/ready handshake. A long press on Boton_Test toggles test mode, and a
// cooldown is inserted after every accepted action.
// Optional build macro ARBITRO_ROUND_ROBIN_EN: rotating priority, where the
// last granted source drops to the lowest priority. When the macro is
// undefined, priority is fixed at Medicina > Comida > Test.
module arbitro_acciones #(
    parameter int TEST_HOLD = 50,
    parameter int COOLDOWN  = 4,
    parameter int HOLD_W    = $clog2(TEST_HOLD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Boton_Comida,
    input  logic               Boton_Medicina,
    input  logic               Boton_Test,
    arbitro_acciones_if.master acc,
    output logic               modo_test,
    output logic               ocupado,
    output logic [7:0]         descartes
);

    localparam logic [1:0] COD_NONE     = 2'b00;
    localparam logic [1:0] COD_COMIDA   = 2'b01;
    localparam logic [1:0] COD_MEDICINA = 2'b10;
    localparam logic [1:0] COD_TEST     = 2'b11;

    // Bit positions inside the synchronizer, request and pending vectors.
    localparam int IDX_C = 0;
    localparam int IDX_M = 1;
    localparam int IDX_T = 2;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TEST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(TEST_HOLD - 1);

    localparam int                COOL_W      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int                COOL_LAST_I = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;
    localparam logic [COOL_W-1:0] COOL_LAST   = COOL_W'(COOL_LAST_I);
    localparam bit                HAS_COOL    = (COOLDOWN > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ENFRIA = 2'd2
    } state_t;

    logic [2:0]        sync1;
    logic [2:0]        sync2;
    logic [2:0]        sync_prev;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_hit;
    logic              rise_c;
    logic              rise_m;
    logic              fall_t;
    logic [2:0]        req;
    logic [2:0]        pend;
    logic [2:0]        clr;
    logic [2:0]        drop;
    logic [1:0]        drop_cnt;
    logic [8:0]        desc_sum;
    logic [2:0]        sel_clr;
    logic [1:0]        sel_code;
    logic              grant_fire;

    state_t            state_q;
    state_t            state_d;
    logic              valida_q;
    logic              valida_d;
    logic [1:0]        codigo_q;
    logic [1:0]        codigo_d;
    logic [COOL_W-1:0] cool_q;
    logic [COOL_W-1:0] cool_d;

    assign acc.accion_valida = valida_q;
    assign acc.accion_codigo = codigo_q;

    // Two-FF synchronizers, plus one extra stage that feeds the edge detectors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
        end else begin
            sync1     <= {Boton_Test, Boton_Medicina, Boton_Comida};
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign rise_c   = sync2[IDX_C] & ~sync_prev[IDX_C];
    assign rise_m   = sync2[IDX_M] & ~sync_prev[IDX_M];
    assign fall_t   = ~sync2[IDX_T] & sync_prev[IDX_T];
    assign hold_hit = sync2[IDX_T] && (hold_cnt == HOLD_PRE);

    // A test-step request is a short press that is released while test mode is on.
    assign req = {fall_t & modo_test & (hold_cnt < HOLD_MAX), rise_m, rise_c};

    // Long-press detection: count the held cycles, then toggle once and saturate until release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            modo_test <= 1'b0;
        end else begin
            if (!sync2[IDX_T]) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (hold_hit) begin
                modo_test <= ~modo_test;
            end
        end
    end

`ifdef ARBITRO_ROUND_ROBIN_EN
    logic [1:0] last_code;

    // Rotating priority on the ring Medicina -> Comida -> Test, starting after the last grant.
    always_comb begin
        sel_clr = 3'b000;
        case (last_code)
            COD_MEDICINA: begin
                if (pend[IDX_C])      sel_clr = 3'b001;
                else if (pend[IDX_T]) sel_clr = 3'b100;
                else if (pend[IDX_M]) sel_clr = 3'b010;
            end
            COD_COMIDA: begin
                if (pend[IDX_T])      sel_clr = 3'b100;
                else if (pend[IDX_M]) sel_clr = 3'b010;
                else if (pend[IDX_C]) sel_clr = 3'b001;
            end
            default: begin
                if (pend[IDX_M])      sel_clr = 3'b010;
                else if (pend[IDX_C]) sel_clr = 3'b001;
                else if (pend[IDX_T]) sel_clr = 3'b100;
            end
        endcase
    end

    // Remember the last granted source. Resetting it to Test gives the order Medicina > Comida > Test.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_code <= COD_TEST;
        end else if (grant_fire) begin
            last_code <= sel_code;
        end
    end
`else
    // Fixed priority: Medicina > Comida > Test.
    always_comb begin
        sel_clr = 3'b000;
        if (pend[IDX_M])      sel_clr = 3'b010;
        else if (pend[IDX_C]) sel_clr = 3'b001;
        else if (pend[IDX_T]) sel_clr = 3'b100;
    end
`endif

    assign sel_code = sel_clr[IDX_M] ? COD_MEDICINA :
                      sel_clr[IDX_C] ? COD_COMIDA   :
                      sel_clr[IDX_T] ? COD_TEST     : COD_NONE;

    // Next-state and next-output logic for IDLE -> GRANT -> ENFRIA.
    always_comb begin
        state_d    = state_q;
        valida_d   = valida_q;
        codigo_d   = codigo_q;
        cool_d     = cool_q;
        grant_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    grant_fire = 1'b1;
                    state_d    = GRANT;
                    valida_d   = 1'b1;
                    codigo_d   = sel_code;
                end
            end
            GRANT: begin
                if (acc.accion_listo) begin
                    valida_d = 1'b0;
                    codigo_d = COD_NONE;
                    cool_d   = '0;
                    state_d  = HAS_COOL ? ENFRIA : IDLE;
                end
            end
            ENFRIA: begin
                if (cool_q == COOL_LAST) begin
                    cool_d  = '0;
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q + COOL_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                valida_d = 1'b0;
                codigo_d = COD_NONE;
                cool_d   = '0;
            end
        endcase
    end

    // FSM state and registered handshake outputs. ocupado tracks the next state so it lines up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            valida_q <= 1'b0;
            codigo_q <= COD_NONE;
            cool_q   <= '0;
            ocupado  <= 1'b0;
        end else begin
            state_q  <= state_d;
            valida_q <= valida_d;
            codigo_q <= codigo_d;
            cool_q   <= cool_d;
            ocupado  <= (state_d != IDLE);
        end
    end

    // A new request in the same cycle as the grant clear wins. A request on a bit that is already pending is a drop.
    assign clr      = grant_fire ? sel_clr : 3'b000;
    assign drop     = req & pend & ~clr;
    assign drop_cnt = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    assign desc_sum = {1'b0, descartes} + {7'b0, drop_cnt};

    // Pending request bits and the saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= '0;
            descartes <= '0;
        end else begin
            pend      <= (pend & ~clr) | req;
            descartes <= desc_sum[8] ? 8'hFF : desc_sum[7:0];
        end
    end

endmodule

// File: tb/tb_arbitro_acciones.sv
// tb_arbitro_acciones: directed stimulus for arbitro_acciones. Expected grants
// go into a scoreboard queue, and a negedge monitor checks every handshake
// against that queue.
module tb_arbitro_acciones;

    localparam int TEST_HOLD = 50;
    localparam int COOLDOWN  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Boton_Comida = 1'b0;
    logic       Boton_Medicina = 1'b0;
    logic       Boton_Test = 1'b0;
    logic       modo_test;
    logic       ocupado;
    logic [7:0] descartes;

    arbitro_acciones_if acc_if ();

    arbitro_acciones #(
        .TEST_HOLD (TEST_HOLD),
        .COOLDOWN  (COOLDOWN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Boton_Comida   (Boton_Comida),
        .Boton_Medicina (Boton_Medicina),
        .Boton_Test     (Boton_Test),
        .acc            (acc_if),
        .modo_test      (modo_test),
        .ocupado        (ocupado),
        .descartes      (descartes)
    );

    typedef struct {
        logic [1:0] code;
        int         gap;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_grant = 0;
    logic       prev_valid = 1'b0;
    logic       prev_listo = 1'b0;
    logic [1:0] prev_code = 2'b00;

    // 100 MHz style clock and a free-running cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [1:0] code, input int gap);
        exp_t x;
        x.code = code;
        x.gap  = gap;
        sb.push_back(x);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic m, input logic t, input int cycles);
        @(posedge clk);
        #1;
        Boton_Comida   = c;
        Boton_Medicina = m;
        Boton_Test     = t;
        repeat (cycles) @(posedge clk);
        #1;
        Boton_Comida   = 1'b0;
        Boton_Medicina = 1'b0;
        Boton_Test     = 1'b0;
    endtask

    // Monitor: checks that a stalled grant stays stable and scores every accepted handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_valid && !prev_listo) begin
                checkOutput("hold_valid", acc_if.accion_valida, 1);
                checkOutput("hold_code", acc_if.accion_codigo, prev_code);
            end
            if (acc_if.accion_valida && acc_if.accion_listo) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_grant: got code %0d, expected no grant", acc_if.accion_codigo);
                end else begin
                    e = sb.pop_front();
                    checkOutput("grant_code", acc_if.accion_codigo, e.code);
                    if (e.gap >= 0) checkOutput("grant_gap", cyc - last_grant, e.gap);
                end
                last_grant <= cyc;
            end
            prev_valid <= acc_if.accion_valida;
            prev_listo <= acc_if.accion_listo;
            prev_code  <= acc_if.accion_codigo;
        end else begin
            prev_valid <= 1'b0;
            prev_listo <= 1'b0;
            prev_code  <= 2'b00;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    // Main directed sequence.
    initial begin
        int   v_cnt;
        int   o_cnt;
        int   first_rise;
        int   rises;
        logic prev_modo;
        logic found;

        acc_if.accion_listo = 1'b0;

        // Reset state.
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst_valid", acc_if.accion_valida, 0);
        checkOutput("rst_code", acc_if.accion_codigo, 0);
        checkOutput("rst_modo", modo_test, 0);
        checkOutput("rst_ocupado", ocupado, 0);
        checkOutput("rst_descartes", descartes, 0);
        reset = 1'b1;
        waitCycles(5);
        checkOutput("idle_valid", acc_if.accion_valida, 0);
        checkOutput("idle_ocupado", ocupado, 0);

        // A single Comida press with ready tied high.
        acc_if.accion_listo = 1'b1;
        pushExp(2'b01, -1);
        v_cnt = 0;
        o_cnt = 0;
        Boton_Comida = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 5) Boton_Comida = 1'b0;
            if (acc_if.accion_valida) v_cnt++;
            if (ocupado) o_cnt++;
        end
        checkOutput("comida_valid_cycles", v_cnt, 1);
        checkOutput("comida_ocupado_cycles", o_cnt, 1 + COOLDOWN);
        checkOutput("comida_descartes", descartes, 0);
        waitCycles(2);

        // Simultaneous Comida and Medicina, done twice.
        for (int k = 0; k < 2; k++) begin
            pushExp(2'b10, -1);
            pushExp(2'b01, 2 + COOLDOWN);
            applyStimulus(1'b1, 1'b1, 1'b0, 3);
            waitCycles(25);
        end

        // Medicina alone, then a pair. Rotating priority now favours Comida.
        pushExp(2'b10, -1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3);
        waitCycles(15);
`ifdef ARBITRO_ROUND_ROBIN_EN
        pushExp(2'b01, -1);
        pushExp(2'b10, 2 + COOLDOWN);
`else
        pushExp(2'b10, -1);
        pushExp(2'b01, 2 + COOLDOWN);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        waitCycles(25);
        checkOutput("sb_drained_pairs", sb.size(), 0);

        // Long Test hold: modo_test rises once, 2 sync cycles plus TEST_HOLD after the press.
        first_rise = -1;
        rises      = 0;
        prev_modo  = modo_test;
        Boton_Test = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            if (modo_test && !prev_modo) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            prev_modo = modo_test;
            if (i == 60) Boton_Test = 1'b0;
        end
        checkOutput("test_hold_rise_cycle", first_rise, 2 + TEST_HOLD);
        checkOutput("test_hold_rises", rises, 1);
        checkOutput("test_hold_modo", modo_test, 1);

        // A short press in test mode gives a test-step after release.
        pushExp(2'b11, -1);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        waitCycles(20);
        checkOutput("test_step_modo", modo_test, 1);

        // A second long hold turns test mode off.
        applyStimulus(1'b0, 1'b0, 1'b1, 60);
        waitCycles(10);
        checkOutput("test_off_modo", modo_test, 0);

        // Stalled grant: three Comida presses with ready low.
        acc_if.accion_listo = 1'b0;
        pushExp(2'b01, -1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 3);
            waitCycles(5);
        end
        checkOutput("stall_valid", acc_if.accion_valida, 1);
        checkOutput("stall_code", acc_if.accion_codigo, 1);
        checkOutput("stall_descartes", descartes, 1);
        pushExp(2'b01, 2 + COOLDOWN);
        acc_if.accion_listo = 1'b1;
        waitCycles(15);
        checkOutput("stall_drained", sb.size(), 0);
        checkOutput("stall_descartes_after", descartes, 1);

        // Reset in the middle of a grant, with test mode on and pending requests present.
        acc_if.accion_listo = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 60);
        waitCycles(5);
        checkOutput("pre_rst_modo", modo_test, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (acc_if.accion_valida) found = 1'b1;
        end
        checkOutput("pre_rst_wait_valid", found, 1);
        checkOutput("pre_rst_code", acc_if.accion_codigo, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        waitCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        waitCycles(4);
        checkOutput("pre_rst_descartes", descartes, 2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", acc_if.accion_valida, 0);
        checkOutput("mid_rst_code", acc_if.accion_codigo, 0);
        checkOutput("mid_rst_modo", modo_test, 0);
        checkOutput("mid_rst_descartes", descartes, 0);
        checkOutput("mid_rst_ocupado", ocupado, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        acc_if.accion_listo = 1'b1;
        waitCycles(15);
        checkOutput("post_rst_ocupado", ocupado, 0);
        checkOutput("post_rst_valid", acc_if.accion_valida, 0);
        checkOutput("post_rst_descartes", descartes, 0);
        checkOutput("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_acciones.md
Name: arbitro_acciones

Overview:
- Arbitrates the three pet buttons (Comida, Medicina, Test) into a single action command for the pet state machine (Maq_Est_Y_Modos core).
- Presents one action at a time over a valid/ready handshake.
- Detects a long press on Boton_Test to toggle test mode.
- Enforces a cooldown between consecutive grants.

Parameters:
- TEST_HOLD, 50: consecutive high cycles of synchronized Boton_Test that toggle modo_test; legal range ≥2.
- COOLDOWN, 4: idle cycles inserted after each accepted action; 0 means no cooldown.
- HOLD_W, $clog2(TEST_HOLD+1): width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Boton_Comida  input  1  food button, active high, asynchronous to clk.
- Boton_Medicina  input  1  medicine button, active high, asynchronous.
- Boton_Test  input  1  test button, active high, asynchronous.
- accion_listo  input  1  ready from the pet FSM.
- accion_valida  output  1  action command valid.
- accion_codigo  output  2  action code: 01 comida, 10 medicina, 11 test-step, 00 none.
- modo_test  output  1  test mode active.
- ocupado  output  1  high when FSM state is not IDLE.
- descartes  output  8  saturating count of dropped requests.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, pending bits 0, synchronizers 0, hold counter 0, cooldown counter 0, FSM=IDLE. Asserting reset mid-GRANT drops accion_valida immediately.
- Input path: each button passes through a 2-FF synchronizer, then a rising-edge detector on the synchronizer output. A pending bit is set on the 3rd rising clk edge after the pin rises.
- Comida/Medicina: a rising edge sets pend_c / pend_m.
- Test button:
  - The hold counter increments while synced Test=1 and clears when it is 0.
  - When the counter reaches TEST_HOLD, modo_test toggles once. The counter then saturates, so there is no further toggling until release.
  - On the falling edge with counter < TEST_HOLD and modo_test=1, pend_t is set.
  - A short press while modo_test=0 is ignored and is not counted as a drop.
- Drops: a request arriving while its pending bit is already 1 increments descartes, saturating at 255.
- FSM states: IDLE, GRANT, ENFRIA.
  - IDLE: if any pending bit is set, select by fixed priority Medicina > Comida > Test. Next cycle: GRANT, accion_valida=1, accion_codigo=selected code, selected pending bit cleared.
  - GRANT: valid and code are held stable until accion_listo=1 is sampled on a rising edge. On that edge, go to ENFRIA (COOLDOWN>0) or IDLE (COOLDOWN=0). valid=0 and codigo=00 from the next cycle.
  - ENFRIA: count COOLDOWN cycles, then IDLE. Requests keep latching during GRANT and ENFRIA.
- Minimum spacing between two grants: 2+COOLDOWN cycles. accion_listo is ignored outside GRANT.
- Simultaneous events:
  - A new edge in the same cycle its pending bit is cleared at grant: set wins, and the new request is kept (no drop).
  - Two edges in the same cycle: both pending bits set, priority order applies.
- modo_test toggling is independent of the FSM and may change during GRANT. An already-pending test-step is still delivered even if modo_test has turned off.
- ocupado = (state != IDLE), registered.

Optional Feature:
- Macro: ARBITRO_ROUND_ROBIN_EN.
- Defined: rotating priority. The last-granted source becomes lowest priority. Ring order is Medicina→Comida→Test. After reset, the pointer gives the fixed order Medicina > Comida > Test.
- Undefined: fixed priority Medicina > Comida > Test only.

Test Plan:
- Reset low 10 cycles, then high, no buttons -> all outputs 0, FSM IDLE, ocupado=0.
- Comida pulse 5 cycles, accion_listo tied 1 -> accion_valida high exactly 1 cycle with codigo=01, ocupado high 1+COOLDOWN=5 cycles, descartes=0.
- Comida and Medicina rise the same cycle, accion_listo=1 -> grants in order 10 then 01, separated by 6 cycles. With ARBITRO_ROUND_ROBIN_EN, a subsequent simultaneous pair (Comida, Medicina) grants 10 first, since the last grant was Comida.
- Boton_Test held 60 cycles -> modo_test rises exactly once, 52 cycles after press (2 sync + 50 hold), no action. A following 10-cycle press -> codigo=11 granted after release. A second 60-cycle hold -> modo_test=0.
- accion_listo=0, Comida pressed 3 separate times -> valid/codigo=01 held stable; first press granted, second pending, third increments descartes to 1. Then accion_listo=1 -> second Comida granted after cooldown.
- Reset asserted while accion_valida=1 -> accion_valida=0 before the next clk edge; pending bits, modo_test and descartes cleared.
